// File: rtl/decoder_pipe.sv
// Registered binary-to-vector decoder (one-hot / thermometer / active-low one-hot)
// with valid/ready on both sides and a 2-entry skid buffer. Define DECODER_PIPE_CNT_EN for xfer_cnt.
module decoder_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DECODER_PIPE_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state, state_nxt;
  logic [OUT_W-1:0] main_q, skid_q;
  logic             main_err, skid_err;
  logic [OUT_W:0]   dec;
  logic             accept, transfer;
  logic             load_main, load_skid, main_from_skid;

  // Returns {err, vector}; out-of-range indices fall out of the one-hot compare as all-zero.
  function automatic logic [OUT_W:0] decode(input logic [IN_W-1:0] idx, input logic [1:0] m);
    logic [OUT_W-1:0] onehot, therm, vec;
    logic             range_err;
    range_err = int'(idx) >= OUT_W;
    for (int i = 0; i < OUT_W; i++) begin
      onehot[i] = (int'(idx) == i);
      therm[i]  = (i <= int'(idx)) && !range_err;
    end
    case (m)
      2'b01:   vec = therm;
      2'b10:   vec = ~onehot;
      default: vec = onehot;
    endcase
    return {range_err | (m == 2'b11), vec};
  endfunction

  assign dec       = decode(in, mode);
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out       = main_q;
  assign out_err   = main_err;
  assign accept    = in_valid & in_ready;
  assign transfer  = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        load_main = 1'b1;
      end
      ONE: begin
        if (accept && transfer) load_main = 1'b1;
        else if (accept) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (transfer) state_nxt = EMPTY;
      end
      TWO: if (transfer) begin
        state_nxt      = ONE;
        load_main      = 1'b1;
        main_from_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // NOTE: both data registers are reset: out must read 0 after reset, and a cleared skid keeps
  // stale data from ever reaching out after a mid-stream reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      main_err <= 1'b0;
      skid_q   <= '0;
      skid_err <= 1'b0;
    end else begin
      if (load_main) begin
        main_q   <= main_from_skid ? skid_q   : dec[OUT_W-1:0];
        main_err <= main_from_skid ? skid_err : dec[OUT_W];
      end
      if (load_skid) begin
        skid_q   <= dec[OUT_W-1:0];
        skid_err <= dec[OUT_W];
      end
    end
  end

`ifdef DECODER_PIPE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        xfer_cnt <= 16'd0;
    else if (transfer) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed self-checking bench for decoder_pipe: a 4->16 instance for the main tests and a
// 4->10 instance for out-of-range indices.
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  in = '0, in10 = '0;
  logic [1:0]  mode = 2'b00, mode10 = 2'b00;
  logic        in_valid = 1'b0, in_valid10 = 1'b0;
  logic        out_ready = 1'b1, out_ready10 = 1'b1;
  logic        in_ready, in_ready10;
  logic [15:0] out;
  logic [9:0]  out10;
  logic        out_err, out_err10, out_valid, out_valid10;
`ifdef DECODER_PIPE_CNT_EN
  logic [15:0] xfer_cnt, xfer_cnt10;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decoder_pipe #(.IN_W(4), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DECODER_PIPE_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  decoder_pipe #(.IN_W(4), .OUT_W(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in(in10), .mode(mode10), .in_valid(in_valid10),
    .in_ready(in_ready10), .out(out10), .out_err(out_err10), .out_valid(out_valid10),
    .out_ready(out_ready10)
`ifdef DECODER_PIPE_CNT_EN
    , .xfer_cnt(xfer_cnt10)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out", 32'(out), 32'h0000);
    check("rst_out_err", 32'(out_err), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
`ifdef DECODER_PIPE_CNT_EN
    check("rst_xfer_cnt", 32'(xfer_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back one-hot sweep, 1-cycle latency
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("sweep_out_%0d", i - 1), 32'(out), 32'(16'd1 << (i - 1)));
        check($sformatf("sweep_err_%0d", i - 1), 32'(out_err), 0);
        check($sformatf("sweep_vld_%0d", i - 1), 32'(out_valid), 1);
      end
      if (i < 16) begin
        in = 4'(i);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
    end
    @(negedge clk);
    check("sweep_drain_vld", 32'(out_valid), 0);

    // Modes with in=5
    in = 4'd5; mode = 2'b01; in_valid = 1'b1;
    @(negedge clk);
    check("therm5", 32'(out), 32'h003F);
    check("therm5_err", 32'(out_err), 0);
    mode = 2'b10;
    @(negedge clk);
    check("alow5", 32'(out), 32'hFFDF);
    check("alow5_err", 32'(out_err), 0);
    mode = 2'b11;
    @(negedge clk);
    check("rsvd5", 32'(out), 32'h0020);
    check("rsvd5_err", 32'(out_err), 1);
    in_valid = 1'b0; mode = 2'b00;
    @(negedge clk);
    check("modes_drain_vld", 32'(out_valid), 0);

    // Backpressure: A=1, B=2, C=3 with out_ready low
    out_ready = 1'b0; in = 4'd1; in_valid = 1'b1;
    @(negedge clk);
    check("bp_a_out", 32'(out), 32'h0002);
    check("bp_a_rdy", 32'(in_ready), 1);
    in = 4'd2;
    @(negedge clk);
    check("bp_full_rdy", 32'(in_ready), 0);
    check("bp_full_out", 32'(out), 32'h0002);
    in = 4'd3;
    @(negedge clk);
    check("bp_hold_rdy", 32'(in_ready), 0);
    check("bp_hold_out", 32'(out), 32'h0002);
    check("bp_hold_vld", 32'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_b_out", 32'(out), 32'h0004);
    check("bp_b_rdy", 32'(in_ready), 1);
    @(negedge clk);
    check("bp_c_out", 32'(out), 32'h0008);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_drain_vld", 32'(out_valid), 0);
    check("bp_drain_rdy", 32'(in_ready), 1);

    // Out-of-range indices on the 10-wide instance
    in10 = 4'd12; mode10 = 2'b00; in_valid10 = 1'b1;
    @(negedge clk);
    check("r10_oh12", 32'(out10), 32'h000);
    check("r10_oh12_err", 32'(out_err10), 1);
    mode10 = 2'b10;
    @(negedge clk);
    check("r10_alow12", 32'(out10), 32'h3FF);
    check("r10_alow12_err", 32'(out_err10), 1);
    in10 = 4'd9; mode10 = 2'b01;
    @(negedge clk);
    check("r10_therm9", 32'(out10), 32'h3FF);
    check("r10_therm9_err", 32'(out_err10), 0);
    mode10 = 2'b00;
    @(negedge clk);
    check("r10_oh9", 32'(out10), 32'h200);
    check("r10_oh9_err", 32'(out_err10), 0);
    in_valid10 = 1'b0;

    // Reset while in TWO
    out_ready = 1'b0; in = 4'd7; mode = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    in = 4'd8;
    @(negedge clk);
    check("mr_two_rdy", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("mr_async_vld", 32'(out_valid), 0);
    check("mr_async_rdy", 32'(in_ready), 1);
    check("mr_async_out", 32'(out), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mr_no_stale_vld", 32'(out_valid), 0);
    end

`ifdef DECODER_PIPE_CNT_EN
    // Counter wrap: 65537 transfers after reset
    check("cnt_after_rst", 32'(xfer_cnt), 0);
    in = 4'd0; in_valid = 1'b1;
    repeat (65537) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("cnt_wrap", 32'(xfer_cnt), 32'h0001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Parametrised, registered binary-to-vector decoder with a valid/ready handshake on both sides and a 2-entry skid buffer. It converts an IN_W-bit index into an OUT_W-bit one-hot, thermometer or active-low one-hot code. It sits between a binary index producer and downstream consumers that need decoded select vectors without combinational paths between the two handshakes. With IN_W=4, OUT_W=16 and mode 00 it yields the standard 4-to-16 one-hot code, one cycle later and flow-controlled.

## Interface
- IN_W, 4, index width; legal range 1..8.
- OUT_W, 16, decoded vector width; must satisfy 2 ≤ OUT_W ≤ 2**IN_W.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in  input  IN_W  binary index.
- mode  input  2  00 one-hot, 01 thermometer, 10 active-low one-hot, 11 reserved.
- in_valid  input  1  in/mode valid.
- in_ready  output  1  block can accept; registered.
- out  output  OUT_W  decoded vector.
- out_err  output  1  qualifies out: index ≥ OUT_W or mode 11.
- out_valid  output  1  out/out_err valid.
- out_ready  input  1  consumer accepts.
- xfer_cnt  output  16  output transfer count; present only with DECODER_PIPE_CNT_EN.

## Operation
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- The decode is computed combinationally from in/mode at accept. Only the decoded result and err are stored.
- Decode with idx = in:
  - 00: bit idx = 1, all other bits 0.
  - 01: bits 0..idx = 1, all other bits 0.
  - 10: bitwise inverse of the 00 result.
- Error cases:
  - idx ≥ OUT_W: the result is all-zero (00/01) or all-ones (10), and err = 1.
  - mode 11: the 00 result is produced and err = 1.
- Storage is a main register (drives out/out_err) plus a skid register. The state machine is:
  - EMPTY: out_valid=0, in_ready=1. Accept → ONE (main loads).
  - ONE: out_valid=1, in_ready=1.
    - Accept & transfer → ONE (main reloads).
    - Accept & !transfer → TWO (skid loads).
    - !accept & transfer → EMPTY.
    - Otherwise hold.
  - TWO: out_valid=1, in_ready=0. Transfer → ONE (main ← skid). Otherwise hold.
- out/out_err are stable while out_valid=1 and out_ready=0.
- No entry is lost or duplicated. Ordering is strict FIFO.
- Inputs are ignored when in_valid=0, and in TWO.
- Reset mid-operation discards both entries. Any pending transfer is lost.

## Timing
- Reset values:
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - out = 0 and out_err = 0 (out is 0 regardless of mode).
  - xfer_cnt = 0.
- Latency: accept in cycle N → out_valid=1 with the result in cycle N+1 (from EMPTY, or from ONE with a simultaneous transfer).
- Throughput: one item per cycle while out_ready=1.
- in_ready is a pure function of the registered state. There is no combinational path from out_ready to in_ready.
- in_ready drops the cycle after the skid fills, and rises the cycle after a transfer in TWO.
- Simultaneous accept and transfer in ONE: the old main value leaves and the new value appears in the next cycle. The skid is untouched.
- Deasserting rst_n clears all state immediately, without waiting for clk. Release is sampled on the next rising clk edge.

## Configuration
- DECODER_PIPE_CNT_EN defined:
  - Port xfer_cnt exists and increments by 1 on every transfer.
  - It wraps 0xFFFF → 0x0000 and resets to 0.
- DECODER_PIPE_CNT_EN undefined:
  - The xfer_cnt port and its counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset check: after reset, out=0x0000, out_valid=0, in_ready=1. Then, with defaults, out_ready=1 and mode 00, sweep in=0..15 back-to-back → out=0x0001..0x8000 one per cycle with 1-cycle latency, err=0.
- Modes: in=5 with mode 01 → out=0x003F; with mode 10 → out=0xFFDF; with mode 11 → out=0x0020, out_err=1.
- Backpressure: out_ready=0 with three items offered → in_ready=0 after the second accept and the third is held. Release out_ready → items arrive in order, no loss or duplication, in_ready returns 1.
- Range (IN_W=4, OUT_W=10): in=12 with mode 00 → out=0x000, out_err=1. in=9 with mode 01 → out=0x3FF, out_err=0.
- Reset mid-stream: pulse rst_n low while in TWO → out_valid=0 and in_ready=1 immediately. No stale item appears after reset release.
- With DECODER_PIPE_CNT_EN: 65537 transfers → xfer_cnt=0x0001.
